// File: rtl/bin_to_bcd_div4_pkg.sv
// rtl/bin_to_bcd_div4_pkg.sv - shared types and constants for the binary-to-BCD converter
package bin_to_bcd_div4_pkg;

    localparam int BCD_W       = 4;
    localparam int BIN_W_DEF   = 7;
    localparam int MAX_VAL_DEF = 99;
    localparam int CNT_W_DEF   = $clog2(BIN_W_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bin_to_bcd_div4_bcd_digit_adjust.sv
// rtl/bin_to_bcd_div4_bcd_digit_adjust.sv - double-dabble "if >= 5 add 3" digit correction
module bcd_digit_adjust
    import bin_to_bcd_div4_pkg::*;
(
    input  logic [BCD_W-1:0] d_i,
    output logic [BCD_W-1:0] d_o
);

    // Result stays 4 bits: inputs never exceed 9 on the legal path, so no carry is lost.
    assign d_o = (d_i >= BCD_W'(5)) ? d_i + BCD_W'(3) : d_i;

endmodule

// File: rtl/bin_to_bcd_div4.sv
// rtl/bin_to_bcd_div4.sv - sequential shift-and-add-3 converter to two BCD digits with Div4 flag
module bin_to_bcd_div4
    import bin_to_bcd_div4_pkg::*;
#(
    parameter int BIN_W   = BIN_W_DEF,
    parameter int MAX_VAL = MAX_VAL_DEF
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [BIN_W-1:0] Bin,
    output logic             Busy,
    output logic             Done,
    output logic [BCD_W-1:0] YT,
    output logic [BCD_W-1:0] YO,
    output logic             Div4,
    output logic             Error
);

    localparam int               CNT_W    = $clog2(BIN_W);
    localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAX_VAL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    state_t             state_q;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   tens_q, ones_q, tens_d, ones_d, tens_adj, ones_adj;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         lsb_q;
    logic               busy_q, done_q, div4_q, err_q;
    logic [BCD_W-1:0]   yt_q, yo_q;

    bcd_digit_adjust u_adj_tens (.d_i(tens_q), .d_o(tens_adj));
    bcd_digit_adjust u_adj_ones (.d_i(ones_q), .d_o(ones_adj));

    // The tens MSB is dropped on the shift: it is always zero for values up to 99.
    assign {tens_d, ones_d, bin_d} = {tens_adj[BCD_W-2:0], ones_adj, bin_q, 1'b0};

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            cnt_q   <= '0;
            lsb_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            div4_q  <= 1'b0;
            err_q   <= 1'b0;
            yt_q    <= '0;
            yo_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (Start) begin
                        busy_q <= 1'b1;
                        if (Bin > MAX_BIN) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            yt_q    <= '0;
                            yo_q    <= '0;
                            div4_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= SHIFT;
                            bin_q   <= Bin;
                            lsb_q   <= Bin[1:0];
                            tens_q  <= '0;
                            ones_q  <= '0;
                            cnt_q   <= '0;
                        end
                    end
                end
                SHIFT: begin
                    tens_q <= tens_d;
                    ones_q <= ones_d;
                    bin_q  <= bin_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        yt_q    <= tens_d;
                        yo_q    <= ones_d;
                        div4_q  <= (lsb_q == 2'b00);
                        err_q   <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy  = busy_q;
    assign Done  = done_q;
    assign YT    = yt_q;
    assign YO    = yo_q;
    assign Div4  = div4_q;
    assign Error = err_q;

endmodule

// File: tb/tb_bin_to_bcd_div4.sv
// tb/tb_bin_to_bcd_div4.sv - self-checking bench for bin_to_bcd_div4 with a result scoreboard
module tb_bin_to_bcd_div4;

    localparam int BIN_W = 7;

    logic             Clock = 1'b0;
    logic             Reset_n = 1'b0;
    logic             Start = 1'b0;
    logic [BIN_W-1:0] Bin = '0;
    logic             Busy, Done, Div4, Error;
    logic [3:0]       YT, YO;

    bin_to_bcd_div4 dut (
        .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .Bin(Bin),
        .Busy(Busy), .Done(Done), .YT(YT), .YO(YO), .Div4(Div4), .Error(Error)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [3:0] yt;
        logic [3:0] yo;
        logic       div4;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   done_cycs[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_n = 0;
    int   done_cyc = 0;

    always @(posedge Clock) cyc++;

    function automatic exp_t model(input int b);
        exp_t e;
        if (b > 99) begin
            e.yt = 4'd0; e.yo = 4'd0; e.div4 = 1'b0; e.err = 1'b1;
        end else begin
            e.yt = 4'(b / 10); e.yo = 4'(b % 10); e.div4 = ((b % 4) == 0); e.err = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge Clock) begin
        if (Reset_n && Done === 1'b1) begin
            exp_t e;
            done_n++;
            done_cyc = cyc;
            done_cycs.push_back(cyc);
            chk("sb_nonempty", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("yt", int'(YT), int'(e.yt));
                chk("yo", int'(YO), int'(e.yo));
                chk("div4", int'(Div4), int'(e.div4));
                chk("error", int'(Error), int'(e.err));
                chk("busy_with_done", int'(Busy), 1);
                if (!e.err)
                    chk("checker_vs_div4", int'(((int'(YT) * 10 + int'(YO)) % 4) == 0), int'(Div4));
            end
        end
    end

    task automatic wait_done(input int target);
        for (int i = 0; i < 50; i++) begin
            @(negedge Clock);
            #1;
            if (done_n >= target) break;
        end
        chk("done_timeout", int'(done_n >= target), 1);
    endtask

    task automatic do_conv(input int b, input int exp_lat);
        int c0, n0;
        @(negedge Clock);
        Start = 1'b1;
        Bin = BIN_W'(b);
        sb.push_back(model(b));
        n0 = done_n;
        @(posedge Clock);
        #1;
        c0 = cyc;
        Start = 1'b0;
        Bin = BIN_W'($urandom);
        wait_done(n0 + 1);
        chk("latency", done_cyc - c0, exp_lat);
        @(negedge Clock);
        chk("busy_after", int'(Busy), 0);
        chk("done_after", int'(Done), 0);
    endtask

    initial begin
        int c0, n0, nc;

        repeat (3) @(negedge Clock);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_done", int'(Done), 0);
        chk("rst_yt", int'(YT), 0);
        chk("rst_yo", int'(YO), 0);
        chk("rst_div4", int'(Div4), 0);
        chk("rst_error", int'(Error), 0);
        Reset_n = 1'b1;

        // Abort a conversion of 57 on the third shift edge
        @(negedge Clock);
        Start = 1'b1;
        Bin = 7'd57;
        sb.push_back(model(57));
        @(posedge Clock);
        #1 Start = 1'b0;
        repeat (3) @(posedge Clock);
        #1 Reset_n = 1'b0;
        #1;
        chk("abort_busy", int'(Busy), 0);
        chk("abort_done", int'(Done), 0);
        chk("abort_yt", int'(YT), 0);
        chk("abort_yo", int'(YO), 0);
        sb.delete();
        n0 = done_n;
        repeat (2) @(negedge Clock);
        Reset_n = 1'b1;
        repeat (12) @(negedge Clock);
        chk("abort_no_done", done_n, n0);
        do_conv(57, BIN_W);

        do_conv(0, BIN_W);

        // Back-to-back 96 then 99 with Start held
        @(negedge Clock);
        Start = 1'b1;
        Bin = 7'd96;
        sb.push_back(model(96));
        sb.push_back(model(99));
        n0 = done_n;
        nc = done_cycs.size();
        @(posedge Clock);
        #1 Bin = 7'd99;
        repeat (BIN_W + 2) @(posedge Clock);
        #1 Start = 1'b0;
        wait_done(n0 + 2);
        if (done_cycs.size() >= nc + 2)
            chk("b2b_period", done_cycs[nc + 1] - done_cycs[nc], BIN_W + 2);
        @(negedge Clock);
        chk("b2b_busy_after", int'(Busy), 0);

        do_conv(100, 0);
        do_conv(52, BIN_W);

        // Start pulses during a conversion of 12 must be ignored
        @(negedge Clock);
        Start = 1'b1;
        Bin = 7'd12;
        sb.push_back(model(12));
        n0 = done_n;
        @(posedge Clock);
        #1 Start = 1'b0;
        Bin = 7'd99;
        @(negedge Clock);
        Start = 1'b1;
        @(posedge Clock);
        #1 Start = 1'b0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Start = 1'b1;
        @(posedge Clock);
        #1 Start = 1'b0;
        repeat (20) @(negedge Clock);
        chk("ignored_start_single_done", done_n - n0, 1);

        for (int b = 0; b < 128; b++)
            do_conv(b, (b > 99) ? 0 : BIN_W);

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
